// File: rtl/bike_bram_stream_reader.sv
// bike_bram_stream_reader: streams a contiguous run of 32-bit words from the
// concatenated polynomial memory (read port B) onto a valid/ready stream.
// A 2-entry output FIFO absorbs the memory's 1-cycle read latency.
// Optional feature: define LAST_WORD_MASK_EN to clear the padding bits above
// R_BITS in the final word of each run.
`timescale 1ns/1ps
module bike_bram_stream_reader #(
  parameter int C      = 2,
  parameter int ADDR_W = $clog2(C) + 10,
  parameter int R_BITS = 12323
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   num_words,
  output logic              ren_b,
  output logic [ADDR_W-1:0] addr_b,
  input  logic [31:0]       dout_b,
  output logic [31:0]       m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  localparam int unsigned TAIL      = R_BITS % 32;
  localparam logic [31:0] LAST_MASK = (TAIL == 0) ? '1 : ((32'd1 << TAIL) - 32'd1);

`ifdef LAST_WORD_MASK_EN
  localparam logic MASK_EN = 1'b1;
`else
  localparam logic MASK_EN = 1'b0;
`endif

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic              infl_q, infl_d;
  logic              infl_last_q, infl_last_d;
  logic [31:0]       buf_data_q [2];
  logic [31:0]       buf_data_d [2];
  logic              buf_last_q [2];
  logic              buf_last_d [2];
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0]        cnt_q, cnt_d;

  logic              pop;
  logic              issue;
  logic [1:0]        occ_after;
  logic [31:0]       cap_data;
  logic              head_last;

  // Next-state: FSM, read issue, FIFO push/pop and occupancy
  always_comb begin
    pop       = (cnt_q != 2'd0) && m_ready;
    head_last = buf_last_q[rd_ptr_q];
    // Occupancy is taken after this cycle's pop so a read can be issued every
    // cycle at full rate; the sum with the in-flight read still never exceeds 2.
    occ_after = cnt_q - {1'b0, pop};
    issue     = (state_q == S_READ) && ((occ_after + {1'b0, infl_q}) < 2'd2);
    cap_data  = (MASK_EN && infl_last_q) ? (dout_b & LAST_MASK) : dout_b;

    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    infl_d      = issue;
    infl_last_d = issue && (rem_q == (ADDR_W+1)'(1));
    buf_data_d  = buf_data_q;
    buf_last_d  = buf_last_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    cnt_d       = cnt_q + {1'b0, infl_q} - {1'b0, pop};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = base_addr;
          rem_d   = num_words;
          state_d = (num_words == '0) ? S_FIN : S_READ;
        end
      end
      S_READ: begin
        if (issue) begin
          addr_d = addr_q + ADDR_W'(1);
          rem_d  = rem_q - (ADDR_W+1)'(1);
          if (rem_q == (ADDR_W+1)'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && head_last) state_d = S_FIN;
      end
      default: state_d = S_IDLE;
    endcase

    if (infl_q) begin
      buf_data_d[wr_ptr_q] = cap_data;
      buf_last_d[wr_ptr_q] = infl_last_q;
      wr_ptr_d             = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        buf_data_q[i] <= '0;
        buf_last_q[i] <= 1'b0;
      end
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
      buf_data_q  <= buf_data_d;
      buf_last_q  <= buf_last_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  // Output decode
  always_comb begin
    ren_b   = issue;
    addr_b  = addr_q;
    m_valid = (cnt_q != 2'd0);
    m_data  = buf_data_q[rd_ptr_q];
    m_last  = m_valid && head_last;
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_FIN);
  end

endmodule

// File: tb/tb_bike_bram_stream_reader.sv
// Self-checking bench for bike_bram_stream_reader: behavioural memory on port B,
// scoreboard queues of expected words and read addresses filled when a start is
// accepted and drained as the DUT issues reads and handshakes words.
`timescale 1ns/1ps
module tb_bike_bram_stream_reader;

  localparam int C     = 2;
  localparam int AW    = 11;
  localparam int DEPTH = 2048;
  localparam int unsigned TAIL = 12323 % 32;

  logic          clk;
  logic          resetn;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   num_words;
  logic          ren_b;
  logic [AW-1:0] addr_b;
  logic [31:0]   dout_b;
  logic [31:0]   m_data;
  logic          m_valid;
  logic          m_last;
  logic          m_ready;
  logic          busy;
  logic          done;

  bike_bram_stream_reader #(.C(C), .R_BITS(12323)) dut (
    .clk(clk), .resetn(resetn), .start(start), .base_addr(base_addr),
    .num_words(num_words), .ren_b(ren_b), .addr_b(addr_b), .dout_b(dout_b),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .busy(busy), .done(done)
  );

  logic [31:0] mem [DEPTH];
  always @(posedge clk) if (ren_b) dout_b <= mem[addr_b];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int nvec = 0;
  int nerr = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard / model state
  logic [32:0]   exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  bit  model_busy   = 1'b0;
  bit  done_pending = 1'b0;
  bit  fv_full      = 1'b0;
  bit  ready_mode   = 1'b0;
  int  nidx = 0, fv_at = -10, fv_end = -10;
  int  issued = 0, popped = 0, hs_total = 0;

  // Downstream ready: tied high or toggling every cycle
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 m_ready = ready_mode ? ~m_ready : 1'b1;
    end
  end

  // Monitor: samples on the falling edge, compares against the scoreboard
  initial begin
    bit exp_done;
    logic [31:0] w;
    forever begin
      @(negedge clk);
      nidx++;
      exp_done     = done_pending;
      done_pending = 1'b0;
      check("done", done, exp_done);
      check("busy", busy, model_busy);

      if (m_valid) begin
        if (exp_q.size() == 0) check("spurious_valid", 1, 0);
        else begin
          check("data", m_data, exp_q[0][31:0]);
          check("last", m_last, exp_q[0][32]);
          if (m_ready) begin
            if (exp_q[0][32]) done_pending = 1'b1;
            void'(exp_q.pop_front());
            popped++;
            hs_total++;
          end
        end
      end

      if (ren_b) begin
        if (exp_addr_q.size() == 0) check("spurious_ren", 1, 0);
        else check("addr", addr_b, exp_addr_q.pop_front());
        issued++;
        check("occupancy", (issued - popped) <= 2, 1);
      end

      if (nidx == fv_at - 1) check("valid_early", m_valid, 0);
      if (fv_full && nidx >= fv_at && nidx <= fv_end) check("valid_rate", m_valid, 1);

      if (start && !model_busy) begin
        model_busy = 1'b1;
        for (int i = 0; i < int'(num_words); i++) begin
          w = mem[(int'(base_addr) + i) % DEPTH];
`ifdef LAST_WORD_MASK_EN
          if (i == int'(num_words) - 1 && TAIL != 0) w = w & (32'hFFFF_FFFF >> (32 - TAIL));
`endif
          exp_q.push_back({(i == int'(num_words) - 1), w});
          exp_addr_q.push_back(AW'((int'(base_addr) + i) % DEPTH));
        end
        if (num_words == '0) begin
          done_pending = 1'b1;
          fv_full      = 1'b0;
        end else begin
          fv_at   = nidx + 3;
          fv_end  = fv_at + int'(num_words) - 1;
          fv_full = !ready_mode;
        end
      end

      if (exp_done) model_busy = 1'b0;
    end
  end

  task automatic run(input logic [AW-1:0] b, input logic [AW:0] n, input int hold);
    @(posedge clk);
    #1;
    base_addr = b;
    num_words = n;
    start     = 1'b1;
    repeat (hold) @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      if (!model_busy && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check("timeout_idle", ok, 1);
    repeat (2) @(posedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ren_b"},   ren_b, 0);
    check({tag, "_addr_b"},  addr_b, 0);
    check({tag, "_m_data"},  m_data, 0);
    check({tag, "_m_valid"}, m_valid, 0);
    check({tag, "_m_last"},  m_last, 0);
    check({tag, "_busy"},    busy, 0);
    check({tag, "_done"},    done, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // Stimulus sequence
  initial begin
    bit ok;
    int target;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'(i);
    mem[300] = 32'h1234_5678;
    mem[301] = 32'hFFFF_FFFF;
    start = 1'b0; base_addr = '0; num_words = '0;
    resetn = 1'b1;
    #1 resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    resetn = 1'b1;

    // Basic run, full rate
    run(11'd0, 12'd4, 1);
    wait_idle();
    // Crosses the bank 0 -> 1 boundary
    run(11'd1022, 12'd4, 1);
    wait_idle();
    // Address wraps modulo 2^ADDR_W
    run(11'd2046, 12'd4, 1);
    wait_idle();
    // Single word: first read is also the last
    run(11'd500, 12'd1, 1);
    wait_idle();

    // Backpressure with a stray start while busy
    ready_mode = 1'b1;
    run(11'd100, 12'd8, 1);
    repeat (3) @(posedge clk);
    run(11'd700, 12'd3, 1);
    wait_idle();
    ready_mode = 1'b0;

    // Zero-length run; start held into FIN must be ignored
    run(11'd50, 12'd0, 2);
    wait_idle();

    // Reset mid-run after three words
    target = hs_total + 3;
    run(11'd200, 12'd8, 1);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      if (hs_total >= target) begin
        ok = 1'b1;
        break;
      end
    end
    check("timeout_3words", ok, 1);
    #1 resetn = 1'b0;
    #1 check_all_zero("midrun_reset");
    exp_q.delete();
    exp_addr_q.delete();
    model_busy = 1'b0; done_pending = 1'b0; fv_full = 1'b0; fv_at = -10;
    issued = 0; popped = 0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (10) @(posedge clk);

    // Last-word masking (or pass-through in the default build)
    run(11'd300, 12'd2, 1);
    wait_idle();
    run(11'd0, 12'd4, 1);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
